seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 restoring integer divider for the Execute/ALU lane; replaces the single-cycle
//  combinational divide on the critical path. Signed or unsigned per operation; quotient+remainder.
//  Start/done handshake to the ALU issue logic; flags follow the ALU overflow/carry convention.
// PARAMETERS
//  N        8    operand/result width in bits (N >= 2)
//  CNT_W    $clog2(N+1)  iteration counter width (derived, do not override)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request; sampled only when busy==0
//  signed_op  in   1   1: two's-complement divide, 0: unsigned; sampled with start
//  A          in   N   dividend, sampled with start
//  B          in   N   divisor, sampled with start
//  busy       out  1   operation in flight (start ignored)
//  done       out  1   one-cycle pulse, results valid this cycle and held until next accepted start
//  out        out  N   quotient
//  rem        out  N   remainder (only with SEQ_DIV_REM_EN)
//  overflow   out  1   signed MIN/-1 overflow
//  car        out  1   carry; tied 0 (ALU flag convention)
//  dbz        out  1   divide-by-zero
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, out=0, rem=0, overflow=0, car=0, dbz=0. Reset wins over start,
//    and mid-operation aborts immediately; no done is produced for the aborted op.
//  - States: IDLE -> (start) LOAD -> ITER (N cycles) -> FIX -> DONE -> IDLE. Zero divisor: LOAD -> DONE.
//  - Start accepted on cycle 0 when in IDLE or DONE; busy=1 from cycle 1 until done is asserted.
//  - LOAD: latch |A|,|B| (magnitudes if signed_op), sign of quotient = A[N-1]^B[N-1], remainder
//    sign = A[N-1]; clear partial remainder, counter=N.
//  - ITER: shift {prem,dividend} left 1; if prem>=|B| subtract, quotient bit=1; counter decrements.
//    Partial remainder N+1 bits wide; magnitudes are N-bit unsigned (|MIN| = 2^(N-1) fits).
//  - FIX: negate quotient/remainder per latched signs (N-bit two's complement wrap).
//  - Latency: done on cycle N+3 after start (start on cycle 0); dbz case done on cycle 2.
//  - Rounding: quotient truncates toward zero; nonzero remainder takes sign of dividend.
//  - B==0: out = all ones, rem = A, dbz=1, overflow=0.
//  - signed_op & A==MIN & B==-1: out = MIN, rem = 0, overflow=1. Unsigned ops never set overflow.
//  - Flags and results update only on the done cycle; done cycle in DONE with start=1 accepts new op
//    (back-to-back issue, no bubble beyond DONE). start while busy is dropped, not queued.
// CONFIGURATION
//  SEQ_DIV_REM_EN defined: rem port present and driven as above.
//  Not defined: rem port absent; remainder restore/negate logic in FIX omitted; quotient, flags and
//  latency unchanged.
// STRUCTURE
//  div_pkg: state enum div_state_t {IDLE,LOAD,ITER,FIX,DONE}, flag struct div_flags_t
//  {overflow,car,dbz}, function abs_n() for magnitude.
//  Sub-module div_step: combinational single restoring iteration (prem_in, dvd_msb, divisor ->
//  prem_out, q_bit); instantiated once, driven by the ITER register loop.
// TESTING (N=8)
//  1. unsigned 100/7 -> done at cycle 11, out=14, rem=2, flags 0.
//  2. signed -100(0x9C)/7 -> out=0xF2 (-14), rem=0xFE (-2); signed 100/-7 -> out=0xF2, rem=0x02.
//  3. signed 0x80/0xFF -> out=0x80, rem=0, overflow=1; same operands unsigned -> out=0x00, rem=0x80, overflow=0.
//  4. 5/0 (either mode) -> done at cycle 2, out=0xFF, rem=5, dbz=1.
//  5. start held high during op with other operands -> ignored; result of first op only; then
//     back-to-back start on done cycle -> second result N+3 cycles later.
//  6. rst asserted at ITER cycle 4 -> next cycle busy=0, outputs 0, no done pulse; new op then correct.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared types and helpers for the sequential radix-2 restoring divider.
//   div_state_t : controller states IDLE -> LOAD -> ITER -> FIX -> DONE
//   div_flags_t : ALU-style result flags {overflow, car, dbz}
//   abs_n()     : two's-complement magnitude on a fixed ABS_W-bit carrier;
//                 callers zero-extend an N-bit operand (N <= ABS_W) and
//                 truncate the result back to N bits.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  typedef struct packed {
    logic overflow;
    logic car;
    logic dbz;
  } div_flags_t;

  localparam int ABS_W = 32;

  // Negating the zero-extended value and keeping the low N bits gives the
  // N-bit magnitude; for MIN this is 2^(N-1), which still fits unsigned.
  function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] v,
                                             input logic             neg);
    return neg ? ({ABS_W{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Issue/result bundle between the ALU issue logic (master) and the divider
// (slave).
//   start, signed_op, A, B : request and operands (master -> slave)
//   busy, done             : status (slave -> master)
//   out, rem               : quotient and remainder (rem only when
//                            SEQ_DIV_REM_EN is defined)
//   overflow, car, dbz     : result flags
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int N = 8
) ();

  logic         start;
  logic         signed_op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
`ifdef SEQ_DIV_REM_EN
  logic [N-1:0] rem;
`endif
  logic         overflow;
  logic         car;
  logic         dbz;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, out,
`ifdef SEQ_DIV_REM_EN
    input  rem,
`endif
    input  overflow, car, dbz
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, out,
`ifdef SEQ_DIV_REM_EN
    output rem,
`endif
    output overflow, car, dbz
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   prem_in_i  : partial remainder before the shift (N+1 bits)
//   dvd_msb_i  : dividend bit shifted into the partial remainder
//   divisor_i  : divisor magnitude (N bits)
//   prem_out_o : partial remainder after the conditional subtract
//   q_bit_o    : quotient bit produced this iteration
// -----------------------------------------------------------------------------
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   prem_in_i,
  input  logic         dvd_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   prem_out_o,
  output logic         q_bit_o
);

  logic [N:0] shifted_s;
  logic       ge_s;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    shifted_s = {prem_in_i[N-1:0], dvd_msb_i};
    // A set bit shifted out of the top guarantees the true value >= divisor.
    ge_s      = prem_in_i[N] | (shifted_s >= {1'b0, divisor_i});
    if (ge_s) begin
      prem_out_o = shifted_s - {1'b0, divisor_i};
    end else begin
      prem_out_o = shifted_s;
    end
    q_bit_o = ge_s;
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring integer divider, signed or unsigned per op.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : seq_divider_if.slave (start/operands in, busy/done/results/flags out)
// Timing: start accepted on cycle 0 in IDLE or DONE; done pulses on cycle N+3
// (cycle 2 for a zero divisor). Results and flags are registered and change
// only on the done cycle.
// Optional: SEQ_DIV_REM_EN adds the remainder output and its sign fix-up.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 8
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  div_state_t   state_q, state_d;
  logic         busy_q, done_q;
  logic [N-1:0] op_a_q, op_b_q;
  logic         op_signed_q;
  logic [N-1:0] dvd_q;
  logic [N:0]   prem_q;
  logic [N-1:0] bmag_q;
  logic [CNT_W-1:0] cnt_q;
  logic         qneg_q, ovf_q;
  logic [N-1:0] out_q;
  div_flags_t   flags_q;
`ifdef SEQ_DIV_REM_EN
  logic         rneg_q;
  logic [N-1:0] rem_q;
`endif

  logic         accept_s, b_zero_s, min_neg1_s;
  logic [N:0]   prem_nx_s;
  logic         q_bit_s;

  assign accept_s   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign b_zero_s   = (op_b_q == {N{1'b0}});
  assign min_neg1_s = op_signed_q && (op_a_q == {1'b1, {(N-1){1'b0}}})
                      && (op_b_q == {N{1'b1}});

  div_step #(.N(N)) u_step (
    .prem_in_i  (prem_q),
    .dvd_msb_i  (dvd_q[N-1]),
    .divisor_i  (bmag_q),
    .prem_out_o (prem_nx_s),
    .q_bit_o    (q_bit_s)
  );

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
        else           state_d = IDLE;
      end
      LOAD: begin
        if (b_zero_s) state_d = DONE;
        else          state_d = ITER;
      end
      ITER: begin
        if (cnt_q == CNT_W'(1)) state_d = FIX;
        else                    state_d = ITER;
      end
      FIX:  state_d = DONE;
      DONE: begin
        if (bus.start) state_d = LOAD;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered busy/done status decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == LOAD) || (state_d == ITER) || (state_d == FIX);
      done_q  <= (state_d == DONE);
    end
  end

  // Datapath: operand capture, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q      <= {N{1'b0}};
      op_b_q      <= {N{1'b0}};
      op_signed_q <= 1'b0;
      dvd_q       <= {N{1'b0}};
      prem_q      <= {(N+1){1'b0}};
      bmag_q      <= {N{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      qneg_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_q       <= {N{1'b0}};
      flags_q     <= '{overflow: 1'b0, car: 1'b0, dbz: 1'b0};
`ifdef SEQ_DIV_REM_EN
      rneg_q      <= 1'b0;
      rem_q       <= {N{1'b0}};
`endif
    end else begin
      if (accept_s) begin
        op_a_q      <= bus.A;
        op_b_q      <= bus.B;
        op_signed_q <= bus.signed_op;
      end
      case (state_q)
        LOAD: begin
          dvd_q  <= N'(abs_n(ABS_W'(op_a_q), op_signed_q & op_a_q[N-1]));
          bmag_q <= N'(abs_n(ABS_W'(op_b_q), op_signed_q & op_b_q[N-1]));
          qneg_q <= op_signed_q & (op_a_q[N-1] ^ op_b_q[N-1]);
          ovf_q  <= min_neg1_s;
          prem_q <= {(N+1){1'b0}};
          cnt_q  <= CNT_W'(N);
`ifdef SEQ_DIV_REM_EN
          rneg_q <= op_signed_q & op_a_q[N-1];
`endif
          // Zero divisor skips the iterations and publishes results directly.
          if (b_zero_s) begin
            out_q   <= {N{1'b1}};
            flags_q <= '{overflow: 1'b0, car: 1'b0, dbz: 1'b1};
`ifdef SEQ_DIV_REM_EN
            rem_q   <= op_a_q;
`endif
          end
        end
        ITER: begin
          dvd_q  <= {dvd_q[N-2:0], q_bit_s};
          prem_q <= prem_nx_s;
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          // MIN / -1 wraps naturally: magnitude 2^(N-1) negated is MIN again.
          out_q   <= qneg_q ? ({N{1'b0}} - dvd_q) : dvd_q;
          flags_q <= '{overflow: ovf_q, car: 1'b0, dbz: 1'b0};
`ifdef SEQ_DIV_REM_EN
          rem_q   <= rneg_q ? ({N{1'b0}} - prem_q[N-1:0]) : prem_q[N-1:0];
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.overflow = flags_q.overflow;
  assign bus.car      = flags_q.car;
  assign bus.dbz      = flags_q.dbz;
`ifdef SEQ_DIV_REM_EN
  assign bus.rem      = rem_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Randomized and directed stimulus for seq_divider (N=8). Each issued op pushes
// its expected result (from integer arithmetic) and due cycle into a queue; a
// monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N = 8;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dbz;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t expq[$];
  exp_t mon_e;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncation toward zero.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sb;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.due = 0;
    if (b == 8'd0) begin
      e.q   = 8'hFF;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -128 && sb == -1) begin
        e.q   = 8'h80;
        e.r   = 8'h00;
        e.ovf = 1'b1;
      end else begin
        e.q = 8'(sa / sb);
        e.r = 8'(sa % sb);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    e     = model(a, b, s);
    e.due = cyc + ((b == 8'd0) ? 2 : N + 3);
    expq.push_back(e);
  endtask

  // Called at a negedge; waits for the divider to accept, drives one start pulse.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    int guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, expected 0", bus.busy, guard);
    end
    bus.start     = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.signed_op = s;
    push_exp(a, b, s);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("quotient", 32'(bus.out), 32'(mon_e.q));
`ifdef SEQ_DIV_REM_EN
        chk("remainder", 32'(bus.rem), 32'(mon_e.r));
`endif
        chk("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
        chk("dbz", 32'(bus.dbz), 32'(mon_e.dbz));
        chk("car", 32'(bus.car), 32'(1'b0));
        chk("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(1'b0));
    chk({tag, "_done"}, 32'(bus.done), 32'(1'b0));
    chk({tag, "_out"}, 32'(bus.out), 32'(8'h00));
`ifdef SEQ_DIV_REM_EN
    chk({tag, "_rem"}, 32'(bus.rem), 32'(8'h00));
`endif
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(1'b0));
    chk({tag, "_car"}, 32'(bus.car), 32'(1'b0));
    chk({tag, "_dbz"}, 32'(bus.dbz), 32'(1'b0));
  endtask

  initial begin
    int guard;
    int sel;
    logic [7:0] ra;
    logic [7:0] rb;
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.A         = 8'd9;
    bus.B         = 8'd3;
    repeat (3) @(negedge clk);
    // start held during reset must not launch anything
    check_cleared("reset");
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'(1'b0));

    // Directed cases, issued back-to-back on done cycles.
    issue(8'd100, 8'd7, 1'b0);
    issue(8'h9C, 8'd7, 1'b1);
    issue(8'd100, 8'hF9, 1'b1);
    issue(8'h80, 8'hFF, 1'b1);
    issue(8'h80, 8'hFF, 1'b0);
    issue(8'd5, 8'd0, 1'b0);
    issue(8'd5, 8'd0, 1'b1);
    issue(8'd255, 8'd1, 1'b0);
    issue(8'h7F, 8'h80, 1'b1);

    // start held high with different operands: ignored until the done cycle.
    guard = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.start     = 1'b1;
    bus.A         = 8'd200;
    bus.B         = 8'd9;
    bus.signed_op = 1'b0;
    push_exp(8'd200, 8'd9, 1'b0);
    @(negedge clk);
    bus.A         = 8'hEF;
    bus.B         = 8'd3;
    bus.signed_op = 1'b1;
    chk("held_busy", 32'(bus.busy), 32'(1'b1));
    guard = 0;
    while (bus.done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++;
      bad++;
      $display("FAIL held_done_timeout: done=%0b after %0d cycles, expected 1", bus.done, guard);
    end
    push_exp(8'hEF, 8'd3, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;

    // Abort: reset during the fourth ITER cycle.
    issue(8'hC8, 8'h0D, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    void'(expq.pop_back());
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    repeat (14) @(negedge clk);
    issue(8'hC8, 8'h0D, 1'b1);

    // Randomized ops with occasional edge operands and idle gaps.
    repeat (60) begin
      sel = $urandom_range(0, 9);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (sel == 0) rb = 8'h00;
      else if (sel == 1) begin
        ra = 8'h80;
        rb = 8'hFF;
      end else if (sel == 2) rb = 8'h01;
      else if (sel == 3) rb = 8'hFF;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (expq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", expq.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
